counter_bus_seq: RTL and testbench

COUNTER_BUS_SEQ -- requirements
Module: counter_bus_seq

---
 rtl/counter_bus_seq_if.sv | 30 +++
 rtl/counter_bus_seq.sv | 152 +++++++++++++++
 tb/tb_counter_bus_seq.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/counter_bus_seq_if.sv
// Bus sequencer port bundle: raw control pins, shared-bus input path, datapath strobes, status.
// Latency: none (signal grouping only).
// Backpressure: none; the sequencer side is the slave, its driver or observer is the master.
interface counter_bus_seq_if;
  // Raw control pins, asynchronous to the core clock
  logic       run_in;
  logic       load_in;
  logic       oe_in;
  // Shared bidirectional bus, input path
  logic [7:0] uio_in;
  // Datapath strobes
  logic       cnt_en;
  logic       cnt_load;
  logic [7:0] load_value;
  // Bus drive enables and status
  logic [7:0] uio_oe;
  logic [7:0] cap_q;
  logic       busy;
  logic       ld_ovf;

  modport slave (
    input  run_in, load_in, oe_in, uio_in,
    output cnt_en, cnt_load, load_value, uio_oe, cap_q, busy, ld_ovf
  );

  modport master (
    output run_in, load_in, oe_in, uio_in,
    input  cnt_en, cnt_load, load_value, uio_oe, cap_q, busy, ld_ovf
  );
endinterface

// File: rtl/counter_bus_seq.sv
// Bus turnaround sequencer: on a load edge, releases the shared bus, captures it, then re-drives it.
// Latency: load pin edge -> RELEASE after 3 edges; capture strobe TURNAROUND cycles after that.
// Backpressure: none; one load request queues while busy, any further request is dropped and flagged.
module counter_bus_seq #(
  parameter int unsigned TURNAROUND    = 1,    // idle cycles before capture and before re-drive (1..3)
  parameter bit          DEFAULT_EN    = 1'b1, // counting allowed even with run_in low
  parameter bit          DEFAULT_DRIVE = 1'b1  // bus driven in DRIVE even with oe_in low
) (
  input logic              clk,
  input logic              rst_n,
  counter_bus_seq_if.slave bus
);

  typedef enum logic [1:0] {
    ST_DRIVE   = 2'd0,
    ST_RELEASE = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RECOVER = 2'd3
  } state_e;

  // Turnaround counter reload: a count of N-1 down to 0 gives exactly N cycles in a timed state.
  localparam logic [1:0] TA_RELOAD = TURNAROUND[1:0] - 2'd1;

  // Synchronizer chains for the asynchronous control pins
  logic       run_s1_q, run_s2_q;
  logic       oe_s1_q, oe_s2_q;
  logic       load_s1_q, load_s2_q, load_s3_q;

  // Sequencer state and registered outputs
  state_e     state_q;
  logic [1:0] tcnt_q;
  logic       pend_q;
  logic       ld_ovf_q;
  logic [7:0] cap_q_q;
  logic       busy_q;
  logic       cnt_load_q;
  logic       drive_q;

  logic       load_rise;
  logic       run_eff;
  logic       oe_eff;

  // Two-flop synchronizers for all pins, plus a third load stage for rising-edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_s1_q  <= 1'b0;
      run_s2_q  <= 1'b0;
      oe_s1_q   <= 1'b0;
      oe_s2_q   <= 1'b0;
      load_s1_q <= 1'b0;
      load_s2_q <= 1'b0;
      load_s3_q <= 1'b0;
    end else begin
      run_s1_q  <= bus.run_in;
      run_s2_q  <= run_s1_q;
      oe_s1_q   <= bus.oe_in;
      oe_s2_q   <= oe_s1_q;
      load_s1_q <= bus.load_in;
      load_s2_q <= load_s1_q;
      load_s3_q <= load_s2_q;
    end
  end

  // One-cycle pulse per synchronized rising edge of the load pin
  assign load_rise = load_s2_q & ~load_s3_q;

  // Parameter overrides force the enables on regardless of the pins
  assign run_eff = DEFAULT_EN | run_s2_q;
  assign oe_eff  = DEFAULT_DRIVE | oe_s2_q;

  // Sequencer FSM with request queue, overflow flag, capture register and registered status outputs.
  // run/oe never enter this block, so they cannot perturb sequence timing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_DRIVE;
      tcnt_q     <= 2'd0;
      pend_q     <= 1'b0;
      ld_ovf_q   <= 1'b0;
      cap_q_q    <= 8'h00;
      busy_q     <= 1'b0;
      cnt_load_q <= 1'b0;
      drive_q    <= 1'b1;
    end else begin
      // Request bookkeeping outside DRIVE: first edge queues, a further edge is lost and flagged.
      // In DRIVE the edge is consumed by the departure below (including when one was already queued).
      if (load_rise && (state_q != ST_DRIVE)) begin
        if (pend_q) begin
          ld_ovf_q <= 1'b1;
        end else begin
          pend_q <= 1'b1;
        end
      end

      case (state_q)
        ST_DRIVE: begin
          if (load_rise || pend_q) begin
            state_q <= ST_RELEASE;
            tcnt_q  <= TA_RELOAD;
            pend_q  <= 1'b0;
            busy_q  <= 1'b1;
            drive_q <= 1'b0;
          end
        end

        ST_RELEASE: begin
          if (tcnt_q == 2'd0) begin
            state_q    <= ST_CAPTURE;
            cnt_load_q <= 1'b1;
          end else begin
            tcnt_q <= tcnt_q - 2'd1;
          end
        end

        ST_CAPTURE: begin
          // Bus value sampled at the closing edge of the single capture cycle
          cap_q_q    <= bus.uio_in;
          state_q    <= ST_RECOVER;
          tcnt_q     <= TA_RELOAD;
          cnt_load_q <= 1'b0;
        end

        ST_RECOVER: begin
          if (tcnt_q == 2'd0) begin
            state_q <= ST_DRIVE;
            busy_q  <= 1'b0;
            drive_q <= 1'b1;
          end else begin
            tcnt_q <= tcnt_q - 2'd1;
          end
        end

        default: begin
          state_q    <= ST_DRIVE;
          tcnt_q     <= 2'd0;
          busy_q     <= 1'b0;
          cnt_load_q <= 1'b0;
          drive_q    <= 1'b1;
        end
      endcase
    end
  end

  // Output decode: load beats increment; bus only driven from DRIVE when output-enabled
  assign bus.cnt_load   = cnt_load_q;
  assign bus.load_value = cnt_load_q ? bus.uio_in : 8'h00;
  assign bus.cnt_en     = run_eff & ~cnt_load_q;
  assign bus.uio_oe     = (drive_q && oe_eff) ? 8'hFF : 8'h00;
  assign bus.cap_q      = cap_q_q;
  assign bus.busy       = busy_q;
  assign bus.ld_ovf     = ld_ovf_q;

endmodule

// File: tb/tb_counter_bus_seq.sv
// Self-checking bench: three sequencer configurations share randomized pin stimulus.
// Latency: expected captures are scheduled from timing rules and matched when cnt_load appears.
// Backpressure: none; the bench drives pins freely every cycle.
module tb_counter_bus_seq;

  localparam int NI   = 3;
  localparam int NCYC = 2000;

  function automatic int unsigned ta_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 3 : 2;
  endfunction

  function automatic bit en_of(input int i);
    return (i == 0) ? 1'b1 : 1'b0;
  endfunction

  function automatic bit drv_of(input int i);
    return (i == 1) ? 1'b0 : 1'b1;
  endfunction

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run_in = 1'b0;
  logic       load_in = 1'b0;
  logic       oe_in = 1'b0;
  logic [7:0] uio_in = 8'h00;

  always #5 clk = ~clk;

  int  cyc = -1;
  int  checks = 0;
  int  errors = 0;
  bit  checking = 1'b0;

  // Pre-drawn bus values so a capture's expected data is known when its sequence starts
  logic [7:0] uio_tab [NCYC+16];
  bit run_h  [NCYC];
  bit load_h [NCYC];
  bit oe_h   [NCYC];

  typedef struct {
    int         cyc;
    logic [7:0] val;
  } cap_exp_t;

  cap_exp_t sbq [NI][$];

  // Expected per-cycle outputs, written just after each rising edge, checked on the falling edge
  bit         e_busy [NI];
  bit         e_load [NI];
  bit         e_en   [NI];
  bit         e_ovf  [NI];
  logic [7:0] e_oe   [NI];
  logic [7:0] e_cap  [NI];

  // Reference model: sequence schedule per instance
  int         m_rst_edge;
  int         m_drive [NI];  // first cycle the instance is back in DRIVE
  int         m_capc  [NI];  // capture cycle of the current/last sequence
  bit         m_pend  [NI];
  bit         m_ovf   [NI];
  logic [7:0] m_cap   [NI];
  bit         rst_prev;
  bit         did_cap_rst;

  task automatic check(input string name, input int inst, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst%0d cycle %0d: got %0h, expected %0h", name, inst, cyc, act, exp);
    end
  endtask

  // Pin value seen at the second synchronizer stage; anything sampled before the last reset reads 0
  function automatic bit eff(input int which, input int k);
    if (k < 0 || k < m_rst_edge) return 1'b0;
    case (which)
      0:       return run_h[k];
      1:       return load_h[k];
      default: return oe_h[k];
    endcase
  endfunction

  task automatic model_step(input int c, input bit reset_now);
    int  t;
    int  s;
    bit  in_drive;
    bit  run;
    bit  oe;
    bit  rise;
    if (reset_now) m_rst_edge = c;
    for (int i = 0; i < NI; i++) begin
      t = int'(ta_of(i));
      if (reset_now) begin
        m_drive[i] = c;
        m_capc[i]  = -1;
        m_pend[i]  = 1'b0;
        m_ovf[i]   = 1'b0;
        m_cap[i]   = 8'h00;
        while (sbq[i].size() > 0 && sbq[i][$].cyc >= c) void'(sbq[i].pop_back());
      end
      in_drive  = (c >= m_drive[i]);
      run       = en_of(i) | eff(0, c - 2);
      oe        = drv_of(i) | eff(2, c - 2);
      e_busy[i] = !in_drive;
      e_load[i] = (c == m_capc[i]);
      e_en[i]   = run & !e_load[i];
      e_oe[i]   = (in_drive && oe) ? 8'hFF : 8'h00;
      e_ovf[i]  = m_ovf[i];
      e_cap[i]  = m_cap[i];

      // Sequence timeline from start edge s: T release, 1 capture, T recover, then DRIVE
      rise = eff(1, c - 2) & !eff(1, c - 3);
      if (in_drive && (rise || m_pend[i])) begin
        s          = c + 1;
        m_capc[i]  = s + t;
        m_drive[i] = s + 2 * t + 1;
        m_pend[i]  = 1'b0;
        sbq[i].push_back('{cyc: s + t, val: uio_tab[s + t]});
      end else if (rise) begin
        if (m_pend[i]) m_ovf[i] = 1'b1;
        else           m_pend[i] = 1'b1;
      end
      if (c == m_capc[i]) m_cap[i] = uio_tab[c];
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_dut
    counter_bus_seq_if u_if ();

    assign u_if.run_in  = run_in;
    assign u_if.load_in = load_in;
    assign u_if.oe_in   = oe_in;
    assign u_if.uio_in  = uio_in;

    counter_bus_seq #(
      .TURNAROUND   (ta_of(g)),
      .DEFAULT_EN   (en_of(g)),
      .DEFAULT_DRIVE(drv_of(g))
    ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (u_if)
    );

    // Monitor: per-cycle status against the model, captures popped from the scoreboard
    always @(negedge clk) begin
      cap_exp_t e;
      if (checking) begin
        check("busy",     g, int'(u_if.busy),     int'(e_busy[g]));
        check("cnt_load", g, int'(u_if.cnt_load), int'(e_load[g]));
        check("cnt_en",   g, int'(u_if.cnt_en),   int'(e_en[g]));
        check("uio_oe",   g, int'(u_if.uio_oe),   int'(e_oe[g]));
        check("ld_ovf",   g, int'(u_if.ld_ovf),   int'(e_ovf[g]));
        check("cap_q",    g, int'(u_if.cap_q),    int'(e_cap[g]));
        if (u_if.cnt_load === 1'b1 && sbq[g].size() > 0) begin
          e = sbq[g].pop_front();
          check("capture_cycle", g, cyc, e.cyc);
          check("load_value",    g, int'(u_if.load_value), int'(e.val));
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < NCYC + 16; k++) uio_tab[k] = 8'($urandom);
    for (int k = 3; k < 60; k++) uio_tab[k] = 8'hA5;
    m_rst_edge  = 0;
    rst_prev    = 1'b0;
    did_cap_rst = 1'b0;

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      cyc = c;

      // Reset: power-on, once exactly during a capture cycle, and once more later for two cycles
      if (c < 3 || c == 1500 || c == 1501) begin
        rst_n = 1'b0;
      end else if (!did_cap_rst && c >= 900 && m_capc[0] == c) begin
        rst_n       = 1'b0;
        did_cap_rst = 1'b1;
      end else begin
        rst_n = 1'b1;
      end

      // Load pin: isolated pulses first, then dense toggling, then sparse random, then quiet tail
      if (c < 600) begin
        load_in = ((c % 37) == 10) || ((c % 37) == 11);
      end else if (c < 1200) begin
        if ($urandom_range(0, 2) == 0) load_in = ~load_in;
      end else if (c < NCYC - 40) begin
        if ($urandom_range(0, 5) == 0) load_in = ~load_in;
      end else begin
        load_in = 1'b0;
      end

      if (c >= 3 && $urandom_range(0, 7) == 0) run_in = ~run_in;
      if (c >= 3 && $urandom_range(0, 7) == 0) oe_in  = ~oe_in;
      uio_in = uio_tab[c];

      run_h[c]  = run_in;
      load_h[c] = load_in;
      oe_h[c]   = oe_in;

      model_step(c, (c == 0) || !rst_prev);
      rst_prev = rst_n;
      checking = 1'b1;
    end

    @(posedge clk);
    #1;
    checking = 1'b0;
    for (int i = 0; i < NI; i++) begin
      check("captures_outstanding", i, sbq[i].size(), 0);
    end
    check("capture_reset_hit", 0, int'(did_cap_rst), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
